// File: rtl/vga_rect_arbiter_pkg.sv
// Shared constants, state encoding and colour palette for the rectangle plot arbiter.
// Clipping to the visible screen is compiled in only when RECT_ARB_CLIP_EN is defined.
package vga_rect_pkg;

   localparam int XSCREEN = 160;
   localparam int YSCREEN = 120;

   localparam int DEF_NREQ = 3;
   localparam int DEF_XW   = 8;
   localparam int DEF_YW   = 7;
   localparam int DEF_DW   = 5;
   localparam int DEF_CW   = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] BLACK  = 3'b000;
   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b110;
   localparam logic [2:0] WHITE  = 3'b111;

endpackage

// File: rtl/vga_rect_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the pointer, with wrap.
module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   idx_o,
   output logic            valid_o
);

   // Walk the requesters starting at the pointer; the first hit wins.
   always_comb begin : pick
      logic [IW-1:0] j;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      j       = '0;
      for (int i = 0; i < NREQ; i++) begin
         j = IW'((int'(ptr_i) + i) % NREQ);
         if (!valid_o && req_i[j]) begin
            valid_o  = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = j;
         end
      end
   end

endmodule

// File: rtl/vga_rect_arbiter.sv
// Round-robin owner of the vga_adapter plot port, walking filled rectangles one pixel per clock.
// Define RECT_ARB_CLIP_EN to suppress plotting of off-screen pixels instead of wrapping.
module vga_rect_arbiter
   import vga_rect_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int XW   = DEF_XW,
   parameter int YW   = DEF_YW,
   parameter int DW   = DEF_DW,
   parameter int CW   = DEF_CW
) (
   input  logic                 CLOCK_50,
   input  logic                 Resetn,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*XW-1:0]   req_x,
   input  logic [NREQ*YW-1:0]   req_y,
   input  logic [NREQ*DW-1:0]   req_w,
   input  logic [NREQ*DW-1:0]   req_h,
   input  logic [NREQ*CW-1:0]   req_colour,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      done,
   output logic                 busy,
   output logic [XW-1:0]        vga_x,
   output logic [YW-1:0]        vga_y,
   output logic [CW-1:0]        vga_colour,
   output logic                 vga_plot
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          state_q;
   logic [IW-1:0]   ptr_q;
   logic [NREQ-1:0] grant_q;
   logic [NREQ-1:0] done_q;
   logic            plot_q;
   logic [XW-1:0]   bx_q;
   logic [YW-1:0]   by_q;
   logic [DW-1:0]   bw_q;
   logic [DW-1:0]   bh_q;
   logic [CW-1:0]   col_q;
   logic [DW-1:0]   cx_q;
   logic [DW-1:0]   cy_q;

   logic [XW-1:0]   xs [NREQ];
   logic [YW-1:0]   ys [NREQ];
   logic [DW-1:0]   ws [NREQ];
   logic [DW-1:0]   hs [NREQ];
   logic [CW-1:0]   cs [NREQ];

   logic [NREQ-1:0] arbGnt;
   logic [IW-1:0]   arbIdx;
   logic            arbValid;
   logic [IW-1:0]   ptr_d;

   for (genvar g = 0; g < NREQ; g++) begin : gUnpack
      assign xs[g] = req_x[g*XW +: XW];
      assign ys[g] = req_y[g*YW +: YW];
      assign ws[g] = req_w[g*DW +: DW];
      assign hs[g] = req_h[g*DW +: DW];
      assign cs[g] = req_colour[g*CW +: CW];
   end

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) uArb (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .gnt_o   (arbGnt),
      .idx_o   (arbIdx),
      .valid_o (arbValid)
   );

   assign ptr_d = (arbIdx == IW'(NREQ - 1)) ? '0 : arbIdx + 1'b1;

   // One FSM owns grant, done, plot and the latched job; the raster counters step in DRAW.
   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         done_q  <= '0;
         plot_q  <= 1'b0;
         bx_q    <= '0;
         by_q    <= '0;
         bw_q    <= '0;
         bh_q    <= '0;
         col_q   <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
      end else begin
         done_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (arbValid) begin
                  bx_q    <= xs[arbIdx];
                  by_q    <= ys[arbIdx];
                  bw_q    <= ws[arbIdx];
                  bh_q    <= hs[arbIdx];
                  col_q   <= cs[arbIdx];
                  cx_q    <= '0;
                  cy_q    <= '0;
                  grant_q <= arbGnt;
                  ptr_q   <= ptr_d;
                  if (ws[arbIdx] == '0 || hs[arbIdx] == '0) begin
                     state_q <= DONE;
                     done_q  <= arbGnt;
                     plot_q  <= 1'b0;
                  end else begin
                     state_q <= DRAW;
                     plot_q  <= 1'b1;
                  end
               end
            end
            DRAW: begin
               if (cx_q == bw_q - 1'b1) begin
                  cx_q <= '0;
                  if (cy_q == bh_q - 1'b1) begin
                     state_q <= DONE;
                     plot_q  <= 1'b0;
                     done_q  <= grant_q;
                  end else begin
                     cy_q <= cy_q + 1'b1;
                  end
               end else begin
                  cx_q <= cx_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               grant_q <= '0;
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
               plot_q  <= 1'b0;
            end
         endcase
      end
   end

   assign grant      = grant_q;
   assign done       = done_q;
   assign busy       = (state_q != IDLE);
   assign vga_colour = col_q;

`ifdef RECT_ARB_CLIP_EN
   logic [XW:0] wideX;
   logic [YW:0] wideY;

   // One extra bit keeps the sum from wrapping back onto the visible area.
   assign wideX    = {1'b0, bx_q} + (XW+1)'(cx_q);
   assign wideY    = {1'b0, by_q} + (YW+1)'(cy_q);
   assign vga_x    = wideX[XW-1:0];
   assign vga_y    = wideY[YW-1:0];
   assign vga_plot = plot_q && (wideX < (XW+1)'(XSCREEN)) && (wideY < (YW+1)'(YSCREEN));
`else
   assign vga_x    = bx_q + XW'(cx_q);
   assign vga_y    = by_q + YW'(cy_q);
   assign vga_plot = plot_q;
`endif

endmodule

// File: tb/tb_vga_rect_arbiter.sv
// Scoreboarded bench for vga_rect_arbiter: expected pixels are queued when a job is
// requested and popped by a negedge monitor whenever the DUT strobes vga_plot.
module tb_vga_rect_arbiter;
   import vga_rect_pkg::*;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   logic        CLOCK_50;
   logic        Resetn;
   logic [2:0]  req;
   logic [23:0] req_x;
   logic [20:0] req_y;
   logic [14:0] req_w;
   logic [14:0] req_h;
   logic [8:0]  req_colour;
   logic [2:0]  grant;
   logic [2:0]  done;
   logic        busy;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;

   pix_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   int   plotCount = 0;
   bit   monitorOn = 1'b0;

   vga_rect_arbiter dut (
      .CLOCK_50   (CLOCK_50),
      .Resetn     (Resetn),
      .req        (req),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_w      (req_w),
      .req_h      (req_h),
      .req_colour (req_colour),
      .grant      (grant),
      .done       (done),
      .busy       (busy),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // Every plotted pixel must match the oldest outstanding expectation.
   always @(negedge CLOCK_50) begin
      if (monitorOn && vga_plot === 1'b1) begin
         pix_t e;
         plotCount++;
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_plot: got x=%0d y=%0d c=%0d, expected no plot", vga_x, vga_y, vga_colour);
         end else begin
            e = expQ.pop_front();
            if (vga_x !== e.x || vga_y !== e.y || vga_colour !== e.c) begin
               errors++;
               $display("[TB] FAIL pixel: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                        vga_x, vga_y, vga_colour, e.x, e.y, e.c);
            end
         end
      end
   end

   task automatic setJob(input int k, input int x, input int y, input int w, input int h, input logic [2:0] c);
      req_x[k*8 +: 8]      = 8'(x);
      req_y[k*7 +: 7]      = 7'(y);
      req_w[k*5 +: 5]      = 5'(w);
      req_h[k*5 +: 5]      = 5'(h);
      req_colour[k*3 +: 3] = c;
   endtask

   task automatic pushRect(input int x, input int y, input int w, input int h, input logic [2:0] c);
      pix_t p;
      for (int cy = 0; cy < h; cy++) begin
         for (int cx = 0; cx < w; cx++) begin
            int wx;
            int wy;
            wx = x + cx;
            wy = y + cy;
`ifdef RECT_ARB_CLIP_EN
            if (wx < 160 && wy < 120) begin
               p = '{x: 8'(wx), y: 7'(wy), c: c};
               expQ.push_back(p);
            end
`else
            p = '{x: 8'(wx % 256), y: 7'(wy % 128), c: c};
            expQ.push_back(p);
`endif
         end
      end
   endtask

   task automatic waitDone(input int budget, output int cyc, output logic [2:0] d,
                           output logic [2:0] g, output bit timedOut);
      cyc = 0;
      d = '0;
      g = '0;
      timedOut = 1'b1;
      while (cyc < budget) begin
         @(negedge CLOCK_50);
         cyc++;
         if (g == 3'b000 && grant != 3'b000) g = grant;
         if (done != 3'b000) begin
            d = done;
            timedOut = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      Resetn = 1'b0;
      req = '0;
      req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
      repeat (3) @(negedge CLOCK_50);
      checks++;
      if ({grant, done, busy, vga_plot} !== 8'b0 || vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'd0) begin
         errors++;
         $display("[TB] FAIL reset_state: got grant=%b done=%b busy=%b plot=%b x=%0d y=%0d c=%0d, expected all zero",
                  grant, done, busy, vga_plot, vga_x, vga_y, vga_colour);
      end
      Resetn = 1'b1;
      monitorOn = 1'b1;
      @(negedge CLOCK_50);
   endtask

   task automatic test_draw_after_reset;
      int cyc; logic [2:0] d, g; bit to; int p0;
      p0 = plotCount;
      setJob(0, 80, 60, 10, 10, YELLOW);
      pushRect(80, 60, 10, 10, YELLOW);
      req = 3'b001;
      waitDone(400, cyc, d, g, to);
      req = 3'b000;
      checks++;
      if (to || cyc != 101 || d !== 3'b001) begin
         errors++;
         $display("[TB] FAIL draw_done: got cycle=%0d done=%b timeout=%0d, expected cycle=101 done=001", cyc, d, to);
      end
      checks++;
      if (g !== 3'b001) begin
         errors++;
         $display("[TB] FAIL draw_grant: got %b, expected 001", g);
      end
      @(negedge CLOCK_50);
      checks++;
      if (busy !== 1'b0 || grant !== 3'b000) begin
         errors++;
         $display("[TB] FAIL draw_idle: got busy=%b grant=%b at cycle 102, expected 0 000", busy, grant);
      end
      checks++;
      if (plotCount - p0 != 100 || expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL draw_plots: got %0d plots, %0d left, expected 100 plots, 0 left", plotCount - p0, expQ.size());
      end
   endtask

   task automatic test_contention;
      int cyc; logic [2:0] d, g; bit to;
      Resetn = 1'b0;
      @(negedge CLOCK_50);
      Resetn = 1'b1;
      setJob(0, 10, 10, 2, 2, RED);
      setJob(1, 20, 20, 2, 2, WHITE);
      setJob(2, 30, 30, 2, 2, YELLOW);
      pushRect(10, 10, 2, 2, RED);
      pushRect(20, 20, 2, 2, WHITE);
      pushRect(30, 30, 2, 2, YELLOW);
      req = 3'b111;
      for (int k = 0; k < 3; k++) begin
         waitDone(100, cyc, d, g, to);
         req[k] = 1'b0;
         if (k == 2) req = 3'b011;
         checks++;
         if (to || d !== 3'(1 << k) || g !== 3'(1 << k) || cyc != (k == 0 ? 5 : 6)) begin
            errors++;
            $display("[TB] FAIL contention_%0d: got done=%b grant=%b cycle=%0d timeout=%0d, expected one-hot %0d cycle %0d",
                     k, d, g, cyc, to, k, (k == 0 ? 5 : 6));
         end
         if (k == 2) begin
            pushRect(10, 10, 2, 2, RED);
            pushRect(20, 20, 2, 2, WHITE);
         end
      end
      for (int k = 0; k < 2; k++) begin
         waitDone(100, cyc, d, g, to);
         req[k] = 1'b0;
         checks++;
         if (to || d !== 3'(1 << k) || g !== 3'(1 << k)) begin
            errors++;
            $display("[TB] FAIL reraise_%0d: got done=%b grant=%b timeout=%0d, expected one-hot %0d", k, d, g, to, k);
         end
      end
      @(negedge CLOCK_50);
      checks++;
      if (expQ.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL contention_drain: got %0d pixels left busy=%b, expected 0 and 0", expQ.size(), busy);
      end
   endtask

   task automatic test_zero_size;
      int cyc; logic [2:0] d, g; bit to; int p0;
      p0 = plotCount;
      setJob(2, 40, 40, 0, 5, RED);
      req = 3'b100;
      waitDone(50, cyc, d, g, to);
      req = 3'b000;
      checks++;
      if (to || cyc != 1 || d !== 3'b100 || g !== 3'b100) begin
         errors++;
         $display("[TB] FAIL zero_size: got cycle=%0d done=%b grant=%b timeout=%0d, expected 1 100 100", cyc, d, g, to);
      end
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      checks++;
      if (plotCount != p0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_size_plots: got %0d plots busy=%b, expected 0 plots busy 0", plotCount - p0, busy);
      end
   endtask

   task automatic test_reset_mid_job;
      int cyc; logic [2:0] d, g; bit to;
      setJob(0, 20, 30, 10, 10, WHITE);
      pushRect(20, 30, 10, 10, WHITE);
      req = 3'b001;
      cyc = 0;
      while (cyc < 37) begin
         @(negedge CLOCK_50);
         cyc++;
      end
      Resetn = 1'b0;
      @(negedge CLOCK_50);
      checks++;
      if (vga_plot !== 1'b0 || grant !== 3'b000 || done !== 3'b000 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mid_job: got plot=%b grant=%b done=%b busy=%b, expected all zero",
                  vga_plot, grant, done, busy);
      end
      checks++;
      if (expQ.size() != 63) begin
         errors++;
         $display("[TB] FAIL reset_mid_job_count: got %0d pixels left, expected 63", expQ.size());
      end
      expQ.delete();
      req = 3'b000;
      Resetn = 1'b1;
      @(negedge CLOCK_50);
      checks++;
      if (done !== 3'b000 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_no_done: got done=%b busy=%b, expected 000 0", done, busy);
      end
      pushRect(20, 30, 10, 10, WHITE);
      req = 3'b001;
      waitDone(400, cyc, d, g, to);
      req = 3'b000;
      checks++;
      if (to || cyc != 101 || d !== 3'b001 || expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL rerequest: got cycle=%0d done=%b left=%0d timeout=%0d, expected 101 001 0",
                  cyc, d, expQ.size(), to);
      end
      @(negedge CLOCK_50);
   endtask

   task automatic test_clip_wrap;
      int cyc; logic [2:0] d, g; bit to; int p0;
      int expPlots [2];
`ifdef RECT_ARB_CLIP_EN
      expPlots[0] = 25;
      expPlots[1] = 0;
`else
      expPlots[0] = 100;
      expPlots[1] = 100;
`endif
      for (int t = 0; t < 2; t++) begin
         int x, y;
         x = (t == 0) ? 155 : 250;
         y = (t == 0) ? 115 : 120;
         p0 = plotCount;
         setJob(1, x, y, 10, 10, RED);
         pushRect(x, y, 10, 10, RED);
         req = 3'b010;
         waitDone(400, cyc, d, g, to);
         req = 3'b000;
         checks++;
         if (to || cyc != 101 || d !== 3'b010) begin
            errors++;
            $display("[TB] FAIL edge_%0d_done: got cycle=%0d done=%b timeout=%0d, expected 101 010", t, cyc, d, to);
         end
         checks++;
         if (plotCount - p0 != expPlots[t] || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL edge_%0d_plots: got %0d plots left=%0d, expected %0d plots", t, plotCount - p0, expQ.size(), expPlots[t]);
         end
         @(negedge CLOCK_50);
      end
   endtask

   task automatic test_param_stability;
      int cyc; logic [2:0] d, g; bit to; bit seen;
      setJob(0, 30, 10, 6, 3, WHITE);
      pushRect(30, 10, 6, 3, WHITE);
      req = 3'b001;
      cyc = 0;
      seen = 1'b0;
      while (cyc < 200 && !seen) begin
         @(negedge CLOCK_50);
         cyc++;
         if (cyc == 3) begin
            req_x[7:0] = 8'd70;
            req_colour[2:0] = RED;
         end
         if (done != 3'b000) seen = 1'b1;
      end
      req = 3'b000;
      checks++;
      if (!seen || cyc != 19 || expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL param_stable: got cycle=%0d seen=%0d left=%0d, expected 19 1 0", cyc, seen, expQ.size());
      end
      @(negedge CLOCK_50);
      pushRect(70, 10, 6, 3, RED);
      req = 3'b001;
      waitDone(200, cyc, d, g, to);
      req = 3'b000;
      checks++;
      if (to || cyc != 19 || d !== 3'b001 || expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL param_next_grant: got cycle=%0d done=%b left=%0d timeout=%0d, expected 19 001 0",
                  cyc, d, expQ.size(), to);
      end
      @(negedge CLOCK_50);
   endtask

   initial begin
      test_reset();
      test_draw_after_reset();
      test_contention();
      test_zero_size();
      test_reset_mid_job();
      test_clip_wrap();
      test_param_stability();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_rect_arbiter.md
Name: vga_rect_arbiter

Overview:
- Sequencer and arbiter for the single vga_adapter plot port (x, y, colour, plot).
- Up to NREQ requesters submit filled-rectangle jobs: snake draw, snake erase, apple draw, apple erase, end-game fill.
- Round-robin grant; the granted job is walked pixel-by-pixel in row-major order, one pixel per clock.
- Sits between the game FSM and vga_adapter, replacing ad-hoc per-state x/y muxing.

Parameters:
- NREQ, 3, number of requesters (2..8)
- XW, 8, x coordinate width
- YW, 7, y coordinate width
- DW, 5, rectangle width/height field width (max 31 pixels)
- CW, 3, colour width
- XSCREEN, 160, visible columns
- YSCREEN, 120, visible rows

Ports:
- CLOCK_50  in  1  system clock
- Resetn  in  1  synchronous, active-low reset
- req  in  NREQ  request per requester; held high until its done pulse
- req_x  in  NREQ*XW  packed top-left x per requester
- req_y  in  NREQ*YW  packed top-left y per requester
- req_w  in  NREQ*DW  packed width per requester
- req_h  in  NREQ*DW  packed height per requester
- req_colour  in  NREQ*CW  packed colour per requester
- grant  out  NREQ  one-hot; high while that job is owned
- done  out  NREQ  one-cycle pulse at job completion
- busy  out  1  high in any state other than IDLE
- vga_x  out  XW  pixel x to the adapter
- vga_y  out  YW  pixel y to the adapter
- vga_colour  out  CW  pixel colour
- vga_plot  out  1  pixel write strobe

Behaviour:
- Reset (Resetn=0 at a CLOCK_50 edge):
  - state=IDLE; grant=0, done=0, busy=0, vga_plot=0.
  - vga_x=0, vga_y=0, vga_colour=0; RR pointer=0; counters=0.
  - Applies mid-job as well: the job is abandoned with no done pulse, and the requester must re-request.
- States: IDLE, DRAW, DONE.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0:
  - Winner = first set bit of req at or after the pointer, searching upward with wrap.
  - Latch the winner's x, y, w, h, colour; grant[winner]=1; cx=cy=0.
  - Pointer = (winner+1) mod NREQ.
  - Go to DRAW, or to DONE directly if w==0 or h==0.
- DRAW, every cycle:
  - vga_x = bx+cx, vga_y = by+cy (mod 2^XW / 2^YW); vga_colour = latched colour; vga_plot=1.
  - If cx==w-1: cx=0 and cy increments; otherwise cx increments.
  - When cx==w-1 and cy==h-1, the next state is DONE.
- DONE (one cycle): done[winner]=1, vga_plot=0; grant clears on exit; next state IDLE.
- Latency: req sampled in IDLE at cycle 0 → first pixel at cycle 1 → last pixel at cycle w*h → done at cycle w*h+1.
  - A back-to-back job's first pixel appears at the earliest at done+2.
- Requester contract:
  - Drop req on the cycle after done.
  - A req still high in IDLE is a new job, but it loses to any other pending request because of the pointer.
- Request parameters are ignored after latching; changing them mid-job has no effect.
- A req deasserted mid-job does not abort the job.
- Simultaneous requests: exactly one grant; the others wait with no loss.
- Outputs are registered except vga_x/vga_y, which are adders on registered values.

Optional Feature:
- RECT_ARB_CLIP_EN defined:
  - vga_plot is forced 0 for any pixel with bx+cx >= XSCREEN or by+cy >= YSCREEN.
  - The sum is computed one bit wider so no wrap occurs.
  - Cycle count is unchanged (w*h DRAW cycles).
- RECT_ARB_CLIP_EN undefined: every DRAW pixel is plotted, and coordinates wrap modulo the port width.

Decomposition:
- Package vga_rect_pkg holds:
  - XSCREEN, YSCREEN, and the default widths.
  - State enum {IDLE, DRAW, DONE}.
  - Colour constants: BLACK=3'b000, RED=3'b100, YELLOW=3'b110, WHITE=3'b111.
- Sub-module rr_arbiter: request vector plus pointer in; one-hot grant and index out; purely combinational.
- Pointer register and latches stay in the parent.

Test Plan:
- Draw after reset: req[0] with x=80, y=60, w=10, h=10, colour=110.
  - Expect 100 plot cycles covering (80..89, 60..69) in row-major order, done[0] at cycle 101, busy low at cycle 102.
- Contention: req=3'b111 in the same cycle, all jobs 2x2, each requester drops req on its own done.
  - Expect grants in order 0, 1, 2, each with 4 plots.
  - Re-raise req=3'b011 while the pointer is at 0: next grant is 0, then 1.
- Zero-size job: w=0, h=5.
  - Expect no plot; done pulses in the cycle after the sample.
- Reset mid-job: Resetn=0 during pixel 37 of a 10x10 job.
  - Next cycle: vga_plot=0, grant=0, no done pulse, busy=0; a new req starts from cx=cy=0.
- Clip with RECT_ARB_CLIP_EN: x=155, y=115, w=10, h=10.
  - Expect 100 DRAW cycles, plot asserted for exactly 25 pixels (155..159, 115..119).
  - Without the macro: 100 plots, with x wrapping 255→0 beyond x=255.
- Parameter stability: change req_x from 30 to 70 on the third DRAW cycle.
  - All pixels keep x in 30..35; the new value is used only on the next grant.
